// File: rtl/mdu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [3:0] OP_MUL   = 4'h7;
   localparam logic [3:0] OP_MULHU = 4'h3;
   localparam logic [3:0] OP_DIVU  = 4'hF;
   localparam logic [3:0] OP_REMU  = 4'hE;

   localparam int unsigned FLAG_DZ   = 0;
   localparam int unsigned FLAG_MSB  = 1;
   localparam int unsigned FLAG_MULH = 2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mdu_state_t;

   function automatic logic is_mdu_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-divide step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_divstep #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN:0]   i_rem,
   input  logic            i_bit,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN:0]   o_rem_c,
   output logic            o_qbit_c
);

   logic [XLEN+1:0] w_shift;
   logic [XLEN+1:0] w_diff;

   // One extra guard bit so the borrow out of the trial subtraction is unambiguous
   assign w_shift  = {i_rem, i_bit};
   assign w_diff   = w_shift - {2'b00, i_divisor};
   assign o_qbit_c = ~w_diff[XLEN+1];
   assign o_rem_c  = o_qbit_c ? w_diff[XLEN:0] : w_shift[XLEN:0];

endmodule

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit with valid/ready request and result handshakes.
// Optional MDU_EARLY_OUT_EN: zero-operand ops finish one cycle after acceptance.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CNTW = $clog2(XLEN)
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_flush,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [3:0]      i_operation,
   input  logic [XLEN-1:0] i_operand1,
   input  logic [XLEN-1:0] i_operand2,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [XLEN-1:0] o_result,
   output logic [3:0]      o_flags
);

   mdu_state_t        r_state, w_state_next;
   logic [CNTW-1:0]   r_count;
   logic [3:0]        r_op;
   logic              r_skip;
   logic [2*XLEN-1:0] r_mcand, r_acc;
   logic [XLEN-1:0]   r_mplier, r_opa, r_divisor, r_quo;
   logic [XLEN:0]     r_rem;
   logic [XLEN-1:0]   r_result;
   logic [3:0]        r_flags;

   logic              w_accept, w_last_iter, w_finish, w_zero, w_skip, w_qbit;
   logic [2*XLEN-1:0] w_acc_next;
   logic [XLEN:0]     w_rem_next;
   logic [XLEN-1:0]   w_quo_next, w_res;
   logic [3:0]        w_flags;

   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = (r_state == DONE);
   assign o_result    = r_result;
   assign o_flags     = r_flags;

   assign w_accept    = (r_state == IDLE) && i_in_valid && !i_flush;
   assign w_last_iter = (r_count == CNTW'(XLEN-1));
   assign w_finish    = (r_state == BUSY) && (r_skip || w_last_iter) && !i_flush;

`ifdef MDU_EARLY_OUT_EN
   assign w_zero = (((i_operation == OP_MUL) || (i_operation == OP_MULHU)) &&
                    ((i_operand1 == '0) || (i_operand2 == '0))) ||
                   (is_div_op(i_operation) && (i_operand2 == '0));
`else
   assign w_zero = 1'b0;
`endif
   assign w_skip = !is_mdu_op(i_operation) || w_zero;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_quo_next = {r_quo[XLEN-2:0], w_qbit};

   mdu_divstep #(.XLEN(XLEN)) u_divstep (
      .i_rem     (r_rem),
      .i_bit     (r_opa[XLEN-1]),
      .i_divisor (r_divisor),
      .o_rem_c   (w_rem_next),
      .o_qbit_c  (w_qbit)
   );

   // Result and flags captured on the finishing edge; skipped ops use the still-unshifted operands
   always_comb begin
      w_res   = '0;
      w_flags = '0;
      if (r_skip) begin
         if (r_op == OP_DIVU)      w_res = '1;
         else if (r_op == OP_REMU) w_res = r_opa;
         w_flags[FLAG_DZ] = is_div_op(r_op);
      end else begin
         unique case (r_op)
            OP_MUL:   w_res = w_acc_next[XLEN-1:0];
            OP_MULHU: w_res = w_acc_next[2*XLEN-1:XLEN];
            OP_DIVU:  w_res = w_quo_next;
            OP_REMU:  w_res = w_rem_next[XLEN-1:0];
            default:  w_res = '0;
         endcase
         w_flags[FLAG_DZ]   = is_div_op(r_op) && (r_divisor == '0);
         w_flags[FLAG_MULH] = (r_op == OP_MUL) && (w_acc_next[2*XLEN-1:XLEN] != '0);
      end
      w_flags[FLAG_MSB] = w_res[XLEN-1];
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (i_in_valid) w_state_next = BUSY;
         BUSY:    if (r_skip || w_last_iter) w_state_next = DONE;
         DONE:    if (i_out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (i_flush) w_state_next = IDLE;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count   <= '0;
         r_op      <= '0;
         r_skip    <= 1'b0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_mplier  <= '0;
         r_opa     <= '0;
         r_divisor <= '0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_result  <= '0;
         r_flags   <= '0;
      end else if (w_accept) begin
         r_count   <= '0;
         r_op      <= i_operation;
         r_skip    <= w_skip;
         r_mcand   <= {{XLEN{1'b0}}, i_operand1};
         r_acc     <= '0;
         r_mplier  <= i_operand2;
         r_opa     <= i_operand1;
         r_divisor <= i_operand2;
         r_quo     <= '0;
         r_rem     <= '0;
      end else if ((r_state == BUSY) && !i_flush) begin
         r_count  <= r_count + 1'b1;
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_opa    <= r_opa << 1;
         r_rem    <= w_rem_next;
         r_quo    <= w_quo_next;
         if (w_finish) begin
            r_result <= w_res;
            r_flags  <= w_flags;
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for mdu: arithmetic, latency, backpressure, async reset and flush.
module tb_mdu;
   import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
   localparam int EO = 1;
`else
   localparam int EO = 0;
`endif

   logic        i_clock, i_reset, i_flush, i_in_valid, o_in_ready;
   logic [3:0]  i_operation;
   logic [31:0] i_operand1, i_operand2, o_result;
   logic        o_out_valid, i_out_ready;
   logic [3:0]  o_flags;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mdu #(.XLEN(32)) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_flush     (i_flush),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_operation (i_operation),
      .i_operand1  (i_operand1),
      .i_operand2  (i_operand2),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_result    (o_result),
      .o_flags     (o_flags)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      p     = {32'h0, a} * {32'h0, b};
      e.res = '0;
      e.flg = '0;
      e.lat = 32;
      case (op)
         OP_MUL: begin
            e.res    = p[31:0];
            e.flg[2] = (p[63:32] != 0);
            if (EO != 0 && (a == 0 || b == 0)) e.lat = 1;
         end
         OP_MULHU: begin
            e.res = p[63:32];
            if (EO != 0 && (a == 0 || b == 0)) e.lat = 1;
         end
         OP_DIVU: begin
            e.res    = (b == 0) ? 32'hFFFF_FFFF : a / b;
            e.flg[0] = (b == 0);
            if (EO != 0 && b == 0) e.lat = 1;
         end
         OP_REMU: begin
            e.res    = (b == 0) ? a : a % b;
            e.flg[0] = (b == 0);
            if (EO != 0 && b == 0) e.lat = 1;
         end
         default: e.lat = 1;
      endcase
      e.flg[1] = e.res[31];
      return e;
   endfunction

   // Drive one request; returns at the falling edge just after the accepting rising edge
   task automatic start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clock);
      check("in_ready_before_req", 64'(o_in_ready), 64'd1);
      i_in_valid  = 1'b1;
      i_operation = op;
      i_operand1  = a;
      i_operand2  = b;
      @(negedge i_clock);
      i_in_valid  = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      sb.push_back(model(op, a, b));
      start(op, a, b);
   endtask

   // Bounded wait for OutValid, then score result/flags/latency against the queue head
   task automatic wait_check(input string tag, output exp_t e);
      int   lat;
      logic rdy_seen;
      lat      = 0;
      rdy_seen = 1'b0;
      while (!o_out_valid && lat < 100) begin
         if (o_in_ready) rdy_seen = 1'b1;
         @(negedge i_clock);
         lat++;
      end
      if (o_in_ready) rdy_seen = 1'b1;
      check({tag, "_inready_busy"}, 64'(rdy_seen), 64'd0);
      if (sb.size() == 0) begin
         check({tag, "_sb_underflow"}, 64'd1, 64'd0);
         e.res = '0; e.flg = '0; e.lat = 0;
      end else begin
         e = sb.pop_front();
         check({tag, "_result"}, 64'(o_result), 64'(e.res));
         check({tag, "_flags"}, 64'(o_flags), 64'(e.flg));
         check({tag, "_latency"}, 64'(lat), 64'(e.lat));
      end
   endtask

   task automatic consume(input string tag);
      i_out_ready = 1'b1;
      @(negedge i_clock);
      i_out_ready = 1'b0;
      check({tag, "_idle_after_consume"}, 64'({o_in_ready, o_out_valid}), 64'(2'b10));
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      exp_t e;
      issue(op, a, b);
      wait_check(tag, e);
      consume(tag);
   endtask

   initial begin
      logic [3:0] ops[4];
      exp_t       e;
      logic       seen;
      ops = '{OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
      i_reset = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_operation = '0; i_operand1 = '0; i_operand2 = '0;

      #1;
      check("reset_in_ready", 64'(o_in_ready), 64'd1);
      check("reset_out_valid", 64'(o_out_valid), 64'd0);
      check("reset_result", 64'(o_result), 64'd0);
      check("reset_flags", 64'(o_flags), 64'd0);
      @(negedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;

      // Test-plan constants, then the general model
      sb.push_back('{res: 32'd42, flg: 4'h0, lat: 32});
      start(OP_MUL, 32'd7, 32'd6);
      wait_check("mul_7x6", e);
      consume("mul_7x6");
      sb.push_back('{res: 32'hFFFF_FFFE, flg: 4'b0010, lat: 32});
      start(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_check("mulhu_ones", e);
      consume("mulhu_ones");
      sb.push_back('{res: 32'h0000_0001, flg: 4'b0100, lat: 32});
      start(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_check("mul_ones", e);
      consume("mul_ones");
      sb.push_back('{res: 32'd14, flg: 4'h0, lat: 32});
      start(OP_DIVU, 32'd100, 32'd7);
      wait_check("divu_100_7", e);
      consume("divu_100_7");
      sb.push_back('{res: 32'd2, flg: 4'h0, lat: 32});
      start(OP_REMU, 32'd100, 32'd7);
      wait_check("remu_100_7", e);
      consume("remu_100_7");
      sb.push_back('{res: 32'hFFFF_FFFF, flg: 4'b0011, lat: (EO != 0) ? 1 : 32});
      start(OP_DIVU, 32'd5, 32'd0);
      wait_check("divu_by0", e);
      consume("divu_by0");
      sb.push_back('{res: 32'd5, flg: 4'b0001, lat: (EO != 0) ? 1 : 32});
      start(OP_REMU, 32'd5, 32'd0);
      wait_check("remu_by0", e);
      consume("remu_by0");

      run_op("other_op", 4'h0, 32'h1234, 32'h5678);
      run_op("mul_zero", OP_MUL, 32'd0, 32'd5);
      run_op("mulhu_zero", OP_MULHU, 32'hDEAD_BEEF, 32'd0);
      run_op("divu_big", OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
      run_op("remu_big", OP_REMU, 32'hDEAD_BEEF, 32'h0000_1234);
      run_op("divu_small_by_big", OP_DIVU, 32'd3, 32'hFFFF_FFF0);
      for (int i = 0; i < 6; i++) begin
         run_op("rand_op", ops[$urandom_range(0, 3)], $urandom, $urandom_range(0, 3) == 0 ?
                32'($urandom_range(0, 9)) : $urandom);
      end

      // Backpressure: result held, new requests ignored until consumed
      issue(OP_MUL, 32'd123456, 32'd789);
      wait_check("bp", e);
      i_in_valid = 1'b1; i_operation = OP_DIVU; i_operand1 = 32'd9; i_operand2 = 32'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clock);
         check("bp_hold", 64'({o_out_valid, o_in_ready, o_flags, o_result}),
               64'({1'b1, 1'b0, 4'h0, 32'd97406784}));
      end
      i_out_ready = 1'b1;
      @(negedge i_clock);
      check("bp_release", 64'({o_in_ready, o_out_valid}), 64'(2'b10));
      i_out_ready = 1'b0;
      i_in_valid  = 1'b0;
      @(negedge i_clock);
      check("bp_not_accepted_on_consume", 64'(o_in_ready), 64'd1);

      // Asynchronous reset in the middle of an operation
      start(OP_MUL, 32'd1000, 32'd1000);
      repeat (10) @(negedge i_clock);
      #1 i_reset = 1'b1;
      #1;
      check("async_reset_out_valid", 64'(o_out_valid), 64'd0);
      check("async_reset_in_ready", 64'(o_in_ready), 64'd1);
      check("async_reset_result", 64'({o_flags, o_result}), 64'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      run_op("mul_3x3_after_reset", OP_MUL, 32'd3, 32'd3);

      // Flush at Count=5 beats a simultaneous request
      start(OP_MUL, 32'd11, 32'd13);
      repeat (5) @(negedge i_clock);
      i_flush = 1'b1; i_in_valid = 1'b1; i_operation = OP_DIVU;
      i_operand1 = 32'd50; i_operand2 = 32'd5;
      @(negedge i_clock);
      i_flush = 1'b0; i_in_valid = 1'b0;
      check("flush_state", 64'({o_in_ready, o_out_valid}), 64'(2'b10));
      seen = 1'b0;
      repeat (40) begin
         @(negedge i_clock);
         if (o_out_valid || !o_in_ready) seen = 1'b1;
      end
      check("flush_no_result", 64'(seen), 64'd0);
      run_op("after_flush", OP_REMU, 32'd50, 32'd6);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
